uart_rx: RTL and testbench

Serial receiver that deserialises frames produced by the team's UART transmitter `tx` on a single board clock. Frame format:
- 1 start bit (0), 8 data bits LSB first, 1 odd-parity bit (`~^data`), 1 stop bit (1).
- Each bit lasts 5209 clock cycles.

It sits between the board's RX pin and the consuming logic. It delivers each byte with a level-held `Received`/`Ack` handshake and per-byte error flags.

---
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8O1 serial receiver with a level-held Received/Ack handshake and per-byte error flags.
// Define UART_RX_PARITY_CHECK_EN to compare the parity bit; otherwise ParityErr is tied 0.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5209,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Sin,
  input  logic       Ack,
  output logic [7:0] Dout,
  output logic       Received,
  output logic       ParityErr,
  output logic       FrameErr,
  output logic       Overrun
);
  typedef enum logic [2:0] {IDLE, START, BITS, PAR, STOP, WAITHI} stateT;

  localparam logic [12:0] HALF_LAST = 13'(HALF_BIT - 1);
  localparam logic [12:0] BIT_LAST  = 13'(CLKS_PER_BIT - 1);

  stateT       state, nextState;
  logic        sMeta, s;
  logic [12:0] baud;
  logic [2:0]  bitNum;
  logic [7:0]  shreg;
  logic        bitDone, clrBaud, clrBitNum, shift, commit;
  logic        parityMismatch;

  assign bitDone = (baud == BIT_LAST);

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (Reset) begin
      sMeta <= 1'b1;
      s     <= 1'b1;
    end else begin
      sMeta <= Sin;
      s     <= sMeta;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state and datapath controls; the timer is held clear outside the timed states.
  always_comb begin
    nextState = state;
    clrBaud   = 1'b0;
    clrBitNum = 1'b0;
    shift     = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        clrBaud = 1'b1;
        if (!s) nextState = START;
        else    nextState = IDLE;
      end
      START: begin
        if (baud == HALF_LAST) begin
          clrBaud   = 1'b1;
          clrBitNum = 1'b1;
          if (s) nextState = IDLE;
          else   nextState = BITS;
        end else begin
          nextState = START;
        end
      end
      BITS: begin
        if (bitDone) begin
          shift   = 1'b1;
          clrBaud = 1'b1;
          if (bitNum == 3'd7) nextState = PAR;
          else                nextState = BITS;
        end else begin
          nextState = BITS;
        end
      end
      PAR: begin
        if (bitDone) begin
          clrBaud   = 1'b1;
          nextState = STOP;
        end else begin
          nextState = PAR;
        end
      end
      STOP: begin
        if (bitDone) begin
          commit  = 1'b1;
          clrBaud = 1'b1;
          if (s) nextState = IDLE;
          else   nextState = WAITHI;
        end else begin
          nextState = STOP;
        end
      end
      WAITHI: begin
        clrBaud = 1'b1;
        if (s) nextState = IDLE;
        else   nextState = WAITHI;
      end
      default: begin
        clrBaud   = 1'b1;
        nextState = IDLE;
      end
    endcase
  end

  // Bit timer, bit counter and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      baud   <= 13'd0;
      bitNum <= 3'd0;
      shreg  <= 8'h00;
    end else begin
      baud <= clrBaud ? 13'd0 : baud + 13'd1;
      if (clrBitNum)                      bitNum <= 3'd0;
      else if (shift && bitNum != 3'd7)   bitNum <= bitNum + 3'd1;
      else                                bitNum <= bitNum;
      if (shift) shreg <= {s, shreg[7:1]};
      else       shreg <= shreg;
    end
  end

`ifdef UART_RX_PARITY_CHECK_EN
  logic parBit;

  function automatic logic oddParity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Parity bit captured mid-bit in PAR, judged against the byte at commit.
  always_ff @(posedge clk) begin
    if (Reset)                     parBit <= 1'b0;
    else if (state == PAR && bitDone) parBit <= s;
    else                           parBit <= parBit;
  end

  assign parityMismatch = (parBit != oddParity(shreg));
`else
  assign parityMismatch = 1'b0;
`endif

  // Committed byte and flags; a commit in the same cycle as Ack wins over the clear.
  always_ff @(posedge clk) begin
    if (Reset) begin
      Dout      <= 8'h00;
      Received  <= 1'b0;
      ParityErr <= 1'b0;
      FrameErr  <= 1'b0;
      Overrun   <= 1'b0;
    end else if (commit) begin
      Dout      <= shreg;
      Received  <= 1'b1;
      FrameErr  <= ~s;
      ParityErr <= parityMismatch;
      Overrun   <= Received & ~Ack;
    end else if (Ack) begin
      Received  <= 1'b0;
    end else begin
      Received  <= Received;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with a shortened bit period; frames are bit-banged onto Sin.
module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int HALF = 8;
  // Cycles from driving the start edge (at a negedge) to the negedge just before the commit edge.
  localparam int COMMIT_NEG = HALF + 10 * CPB + 2;
`ifdef UART_RX_PARITY_CHECK_EN
  localparam logic PCHK = 1'b1;
`else
  localparam logic PCHK = 1'b0;
`endif

  logic        clk, Reset, Sin, Ack;
  logic [7:0]  Dout;
  logic        Received, ParityErr, FrameErr, Overrun;
  logic [11:0] obs;
  logic [11:0] expQ[$];
  logic [11:0] exp;
  int          total = 0;
  int          bad   = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
    .clk(clk), .Reset(Reset), .Sin(Sin), .Ack(Ack),
    .Dout(Dout), .Received(Received), .ParityErr(ParityErr),
    .FrameErr(FrameErr), .Overrun(Overrun)
  );

  assign obs = {Dout, Received, ParityErr, FrameErr, Overrun};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] mk(input logic [7:0] d, input logic r, input logic pe,
                                     input logic fe, input logic ov);
    return {d, r, pe, fe, ov};
  endfunction

  // Drives start, 8 data bits LSB first, parity and stop; starts and ends on a negedge.
  task automatic sendFrame(input logic [7:0] d, input logic p, input logic stp);
    logic [10:0] bits;
    bits = {stp, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      Sin = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic sendGood(input logic [7:0] d);
    sendFrame(d, ~^d, 1'b1);
  endtask

  task automatic ackPulse();
    Ack = 1'b1;
    @(negedge clk);
    Ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1; Sin = 1'b1; Ack = 1'b0;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    expQ.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    exp = expQ.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL reset_state: got %h want %h", obs, exp); end
  endtask

  task automatic test_loopback();
    expQ.push_back(mk(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0));
    sendGood(8'hA5);
    exp = expQ.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL loopback_rx: got %h want %h", obs, exp); end
    expQ.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0));
    Ack = 1'b1;
    @(negedge clk);
    Ack = 1'b0;
    exp = expQ.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL loopback_ack: got %h want %h", obs, exp); end
    expQ.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0));
    ackPulse();
    exp = expQ.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL idle_ack_ignored: got %h want %h", obs, exp); end
  endtask

  task automatic test_bad_parity();
    expQ.push_back(mk(8'h01, 1'b1, PCHK, 1'b0, 1'b0));
    sendFrame(8'h01, 1'b1, 1'b1);
    exp = expQ.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL bad_parity: got %h want %h", obs, exp); end
    ackPulse();
  endtask

  task automatic test_framing();
    expQ.push_back(mk(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0));
    sendFrame(8'h3C, 1'b1, 1'b0);
    repeat (200) @(negedge clk);
    exp = expQ.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL framing_err: got %h want %h", obs, exp); end
    expQ.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0));
    ackPulse();
    repeat (100) @(negedge clk);
    exp = expQ.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL break_no_rearm: got %h want %h", obs, exp); end
    Sin = 1'b1;
    repeat (CPB) @(negedge clk);
    expQ.push_back(mk(8'h96, 1'b1, 1'b0, 1'b0, 1'b0));
    sendGood(8'h96);
    exp = expQ.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL after_break_rx: got %h want %h", obs, exp); end
    ackPulse();
  endtask

  task automatic test_false_start();
    expQ.push_back(mk(8'h96, 1'b0, 1'b0, 1'b0, 1'b0));
    Sin = 1'b0;
    repeat (4) @(negedge clk);
    Sin = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    exp = expQ.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL false_start: got %h want %h", obs, exp); end
    expQ.push_back(mk(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0));
    sendGood(8'h7E);
    exp = expQ.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL post_glitch_rx: got %h want %h", obs, exp); end
    ackPulse();
  endtask

  task automatic test_back_to_back();
    expQ.push_back(mk(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0));
    sendGood(8'h3C);
    exp = expQ.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL b2b_first: got %h want %h", obs, exp); end
    expQ.push_back(mk(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1));
    sendGood(8'hC3);
    exp = expQ.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL overrun_set: got %h want %h", obs, exp); end
    // Third frame: Ack lands exactly on its commit edge.
    expQ.push_back(mk(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1));
    expQ.push_back(mk(8'h11, 1'b1, 1'b0, 1'b0, 1'b0));
    fork
      sendGood(8'h11);
      begin
        repeat (COMMIT_NEG) @(negedge clk);
        exp = expQ.pop_front(); total++;
        if (obs !== exp) begin bad++; $display("FAIL pre_commit_hold: got %h want %h", obs, exp); end
        Ack = 1'b1;
        @(negedge clk);
        Ack = 1'b0;
      end
    join
    exp = expQ.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL ack_commit_race: got %h want %h", obs, exp); end
  endtask

  task automatic test_reset_mid_frame();
    expQ.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    expQ.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    fork
      sendGood(8'hFF);
      begin
        repeat (5 * CPB + HALF) @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        exp = expQ.pop_front(); total++;
        if (obs !== exp) begin bad++; $display("FAIL mid_reset_clear: got %h want %h", obs, exp); end
      end
    join
    repeat (2 * CPB) @(negedge clk);
    exp = expQ.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL no_partial_commit: got %h want %h", obs, exp); end
    expQ.push_back(mk(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0));
    sendGood(8'h5A);
    exp = expQ.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL post_reset_rx: got %h want %h", obs, exp); end
  endtask

  initial begin
    Reset = 1'b1; Sin = 1'b1; Ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_loopback();
    test_bad_parity();
    test_framing();
    test_false_start();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
